contador_modn: RTL and testbench

CONTADOR_MODN -- requirements
Module: contador_modn

---
 rtl/contador_modn.sv | 77 +++++++
 tb/tb_contador_modn.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/contador_modn.sv
// Modulo-N up/down counter with parallel load, optional one-shot stop,
// combinational terminal-count for cascading and a registered wrap/stop pulse.
module contador_modn #(
  parameter int MODULO = 10,
  parameter int WIDTH  = 4
) (
  input  logic             clk,
  input  logic             clearn,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             en,
  input  logic             dir,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             count_end,
  output logic             running
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  // ST_STOP is the one-shot parked state; only load or clearn leaves it.
  typedef enum logic {ST_RUN = 1'b0, ST_STOP = 1'b1} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] count_next;
  logic             end_next;
  logic [WIDTH-1:0] terminal;
  logic             at_term;
  logic [WIDTH-1:0] load_val;

  always_comb begin
    terminal = dir ? MAX_VAL : '0;
    at_term  = (count == terminal);
    // Compare one bit wider so MODULO == 2**WIDTH is handled correctly.
    load_val = ({1'b0, data} >= MOD_EXT) ? MAX_VAL : data;
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state     <= ST_RUN;
      count     <= '0;
      count_end <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      count_end <= end_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    end_next   = 1'b0;
    if (!load) begin
      count_next = load_val;
      state_next = ST_RUN;
    end else if (en && state == ST_RUN) begin
      if (!at_term) begin
        count_next = dir ? count + 1'b1 : count - 1'b1;
      end else if (oneshot) begin
        state_next = ST_STOP;
        end_next   = 1'b1;
      end else begin
        count_next = dir ? '0 : MAX_VAL;
        end_next   = 1'b1;
      end
    end
  end

  always_comb begin
    running = (state == ST_RUN);
    tc      = en && at_term && (state == ST_RUN);
  end

endmodule

// File: tb/tb_contador_modn.sv
// Directed bench for contador_modn (MODULO=10, WIDTH=4): vector table,
// asynchronous-reset sequences and a two-stage cascade.
module tb_contador_modn;

  logic       clk = 1'b0;
  logic       clearn, load, en, dir, oneshot;
  logic [3:0] data;
  logic [3:0] count;
  logic       tc, count_end, running;

  logic       c_clearn, c_en;
  logic [3:0] lo_count, hi_count;
  logic       lo_tc, hi_tc, lo_end, hi_end, lo_run, hi_run;
  logic [3:0] c_data;
  logic       c_load, c_dir, c_os;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       ld;
    logic [3:0] d;
    logic       en;
    logic       dir;
    logic       os;
    logic [3:0] cnt;
    logic       tc;
    logic       ce;
    logic       run;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  contador_modn #(.MODULO(10), .WIDTH(4)) dut (
    .clk(clk), .clearn(clearn), .data(data), .load(load), .en(en),
    .dir(dir), .oneshot(oneshot), .count(count), .tc(tc),
    .count_end(count_end), .running(running)
  );

  contador_modn #(.MODULO(10), .WIDTH(4)) c_lo (
    .clk(clk), .clearn(c_clearn), .data(c_data), .load(c_load), .en(c_en),
    .dir(c_dir), .oneshot(c_os), .count(lo_count), .tc(lo_tc),
    .count_end(lo_end), .running(lo_run)
  );

  contador_modn #(.MODULO(10), .WIDTH(4)) c_hi (
    .clk(clk), .clearn(c_clearn), .data(c_data), .load(c_load), .en(lo_tc),
    .dir(c_dir), .oneshot(c_os), .count(hi_count), .tc(hi_tc),
    .count_end(hi_end), .running(hi_run)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ld, input logic [3:0] d, input logic e, input logic dr,
                     input logic os, input logic [3:0] c, input logic t, input logic ce,
                     input logic r);
    vec_t v;
    v = '{ld: ld, d: d, en: e, dir: dr, os: os, cnt: c, tc: t, ce: ce, run: r};
    vq.push_back(v);
  endtask

  task automatic check_main(input string tag, input logic [3:0] c, input logic t,
                            input logic ce, input logic r);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".tc"}, 32'(tc), 32'(t));
    check({tag, ".count_end"}, 32'(count_end), 32'(ce));
    check({tag, ".running"}, 32'(running), 32'(r));
  endtask

  initial begin
    int v, prev;
    clearn = 1'b0; load = 1'b1; en = 1'b0; dir = 1'b0; oneshot = 1'b0; data = '0;
    c_clearn = 1'b0; c_en = 1'b0; c_data = '0; c_load = 1'b1; c_dir = 1'b1; c_os = 1'b0;

    //   ld d  en dir os  cnt tc ce run
    // Load 6, count down with wrap
    add(0, 6, 0, 0, 0,  6, 0, 0, 1);
    add(1, 0, 1, 0, 0,  5, 0, 0, 1);
    add(1, 0, 1, 0, 0,  4, 0, 0, 1);
    add(1, 0, 1, 0, 0,  3, 0, 0, 1);
    add(1, 0, 1, 0, 0,  2, 0, 0, 1);
    add(1, 0, 1, 0, 0,  1, 0, 0, 1);
    add(1, 0, 1, 0, 0,  0, 1, 0, 1);
    add(1, 0, 1, 0, 0,  9, 0, 1, 1);
    add(1, 0, 1, 0, 0,  8, 0, 0, 1);
    // Saturating load, then up-wrap
    add(0, 15, 0, 1, 0, 9, 0, 0, 1);
    add(1, 0, 1, 1, 0,  0, 0, 1, 1);
    add(1, 0, 1, 1, 0,  1, 0, 0, 1);
    // One-shot down from 2
    add(0, 2, 0, 0, 1,  2, 0, 0, 1);
    add(1, 0, 1, 0, 1,  1, 0, 0, 1);
    add(1, 0, 1, 0, 1,  0, 1, 0, 1);
    add(1, 0, 1, 0, 1,  0, 0, 1, 0);
    add(1, 0, 1, 0, 1,  0, 0, 0, 0);
    add(1, 0, 1, 1, 1,  0, 0, 0, 0);
    add(0, 5, 0, 1, 0,  5, 0, 0, 1);
    // Direction change mid-count, then hold
    add(0, 3, 0, 1, 0,  3, 0, 0, 1);
    add(1, 0, 1, 1, 0,  4, 0, 0, 1);
    add(1, 0, 1, 0, 0,  3, 0, 0, 1);
    add(1, 0, 0, 0, 0,  3, 0, 0, 1);
    add(1, 0, 0, 0, 0,  3, 0, 0, 1);
    add(1, 0, 0, 0, 0,  3, 0, 0, 1);
    // Load boundaries and load-over-enable priority
    add(0, 10, 0, 1, 0, 9, 0, 0, 1);
    add(0, 9, 1, 1, 0,  9, 1, 0, 1);
    add(1, 0, 1, 1, 0,  0, 0, 1, 1);
    // Load into terminal, stop, load leaves stop without a pulse
    add(0, 0, 1, 0, 1,  0, 1, 0, 1);
    add(1, 0, 1, 0, 1,  0, 0, 1, 0);
    add(0, 7, 1, 0, 1,  7, 0, 0, 1);

    #12;
    check_main("reset", 4'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    clearn = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      load = vq[i].ld; data = vq[i].d; en = vq[i].en; dir = vq[i].dir; oneshot = vq[i].os;
      @(posedge clk);
      #1;
      check_main($sformatf("vec%0d", i), vq[i].cnt, vq[i].tc, vq[i].ce, vq[i].run);
    end

    // Asynchronous clear mid-cycle at count 7; load held low under reset
    @(negedge clk);
    load = 1'b1; en = 1'b0;
    #2 clearn = 1'b0;
    #1 check_main("async_clr", 4'd0, 1'b0, 1'b0, 1'b1);
    load = 1'b0; data = 4'd5;
    @(posedge clk);
    #1 check("clr_over_load.count", 32'(count), 32'd0);
    @(negedge clk);
    clearn = 1'b1; load = 1'b1; en = 1'b1; dir = 1'b1; oneshot = 1'b0;
    @(posedge clk);
    #1 check_main("post_clr", 4'd1, 1'b0, 1'b0, 1'b1);

    // Clear while stopped and while count_end is high
    @(negedge clk);
    load = 1'b0; data = 4'd9; oneshot = 1'b1;
    @(posedge clk);
    #1 check_main("pre_stop", 4'd9, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    load = 1'b1;
    @(posedge clk);
    #1 check_main("stop", 4'd9, 1'b0, 1'b1, 1'b0);
    #2 clearn = 1'b0;
    #1 check_main("clr_stop", 4'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    clearn = 1'b1; en = 1'b0;

    // Two-stage cascade, 100 cycles
    c_clearn = 1'b1;
    @(negedge clk);
    c_en = 1'b1;
    v = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      prev = v;
      v = (v + 1) % 100;
      check($sformatf("casc%0d.lo", i), 32'(lo_count), 32'(v % 10));
      check($sformatf("casc%0d.hi", i), 32'(hi_count), 32'(v / 10));
      check($sformatf("casc%0d.hi_tc", i), 32'(hi_tc), 32'(v == 99));
      check($sformatf("casc%0d.hi_end", i), 32'(hi_end), 32'(prev == 99));
      check($sformatf("casc%0d.lo_end", i), 32'(lo_end), 32'((prev % 10) == 9));
    end
    check("casc.lo_run", 32'(lo_run), 32'd1);
    check("casc.hi_run", 32'(hi_run), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
